spm_issue_sequencer: RTL and testbench

Upstream/downstream companion stage for the serial-parallel multiplier (SPM). It buffers signed operand pairs arriving on a valid/ready stream and issues them to the SPM one at a time. Each issue drives MP/MC with a one-cycle start pulse, waits for done, and returns the 64-bit product on a valid/ready output stream. Operations are strictly in order, with at most one multiplication in flight.

---
 rtl/spm_pkg.sv | 17 +
 rtl/spm_operand_fifo.sv | 68 ++++++
 rtl/spm_issue_sequencer.sv | 147 ++++++++++++++
 tb/tb_spm_issue_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared definitions for the SPM issue sequencer.
//   SPM_W               default operand width of the serial-parallel multiplier
//   SPM_TIMEOUT_CYCLES  default watchdog limit, in cycles from the start pulse
//   seq_state_t         sequencer FSM state encoding
package spm_pkg;

    localparam int SPM_W              = 32;
    localparam int SPM_TIMEOUT_CYCLES = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/spm_operand_fifo.sv
// spm_operand_fifo: synchronous FIFO holding packed {mp, mc} operand pairs.
// Ports:
//   clk, reset    clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata   write strobe and data; ignored while ready is low
//   pop, rdata    read strobe and head-of-queue data (rdata valid while !empty)
//   empty         no entries stored
//   ready         registered "not full"; low during reset
module spm_operand_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ready <= (count_next != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spm_issue_sequencer.sv
// spm_issue_sequencer: buffers signed operand pairs and issues them one at a
// time to a serial-parallel multiplier, returning each 2W-bit product on a
// valid/ready stream. Strictly in order, at most one multiplication in flight.
// Optional feature macro: SPM_SEQ_TIMEOUT_EN enables a watchdog that ends a
// stuck multiplication with out_p=0, out_err=1.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready/in_mp/in_mc   operand input stream
//   out_valid/out_ready/out_p/out_err  product output stream
//   spm_mp/spm_mc/spm_start         operands and one-cycle start pulse to SPM
//   spm_p/spm_done                  product and done level from SPM
//   busy                            FSM active or operands queued
module spm_issue_sequencer
    import spm_pkg::*;
#(
    parameter int W              = SPM_W,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = SPM_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_mp,
    input  logic signed [W-1:0] in_mc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [2*W-1:0] out_p,
    output logic                out_err,
    output logic signed [W-1:0] spm_mp,
    output logic signed [W-1:0] spm_mc,
    output logic                spm_start,
    input  logic signed [2*W-1:0] spm_p,
    input  logic                spm_done,
    output logic                busy
);

    seq_state_t       state;
    logic             done_q;
    logic             done_rise;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [2*W-1:0]   fifo_rdata;

`ifdef SPM_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
`endif

    spm_operand_fifo #(
        .WIDTH (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata ({in_mp, in_mc}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .ready (in_ready)
    );

    // Only a fresh rising edge of done counts; a level held over from the
    // previous operation must not complete the new one.
    assign done_rise = spm_done && !done_q;

    // A pop happens from IDLE, or from HOLD as the result is handed off.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == HOLD && out_ready));
    assign busy     = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            spm_start <= 1'b0;
            spm_mp    <= '0;
            spm_mc    <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
`ifdef SPM_SEQ_TIMEOUT_EN
            out_err   <= 1'b0;
            wd        <= '0;
`endif
        end else begin
            done_q    <= spm_done;
            spm_start <= 1'b0;
            if (fifo_pop) begin
                spm_mp <= fifo_rdata[2*W-1:W];
                spm_mc <= fifo_rdata[W-1:0];
            end
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        spm_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
`ifdef SPM_SEQ_TIMEOUT_EN
                    wd    <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        out_p     <= spm_p;
                        out_valid <= 1'b1;
`ifdef SPM_SEQ_TIMEOUT_EN
                        out_err   <= 1'b0;
`endif
                        state     <= HOLD;
                    end
`ifdef SPM_SEQ_TIMEOUT_EN
                    // Expires on the TIMEOUT_CYCLES-th WAIT cycle, so out_valid
                    // appears TIMEOUT_CYCLES+1 cycles after the start pulse.
                    else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        out_p     <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (fifo_pop) begin
                            spm_start <= 1'b1;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SPM_SEQ_TIMEOUT_EN
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_spm_issue_sequencer.sv
// Testbench for spm_issue_sequencer with a behavioural SPM model.
module tb_spm_issue_sequencer;

    localparam int W    = 32;
    localparam int TOUT = 128;
    localparam int LAT  = 10;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [W-1:0]   in_mp = '0;
    logic signed [W-1:0]   in_mc = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [2*W-1:0] out_p;
    logic                  out_err;
    logic signed [W-1:0]   spm_mp;
    logic signed [W-1:0]   spm_mc;
    logic                  spm_start;
    logic signed [2*W-1:0] spm_p;
    logic                  spm_done;
    logic                  busy;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    logic signed [2*W-1:0] got_p[$];
    logic                  got_err[$];

    bit stale_mode = 0;
    bit hang = 0;

    spm_issue_sequencer #(.W(W), .DEPTH(4), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mp(in_mp), .in_mc(in_mc),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_err(out_err),
        .spm_mp(spm_mp), .spm_mc(spm_mc), .spm_start(spm_start),
        .spm_p(spm_p), .spm_done(spm_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural SPM: LAT cycles after start, done rises with the product and
    // then stays high until the next start. In stale_mode the old done level
    // and old product persist for a while after the start, then done drops
    // for two cycles before rising with the new product.
    logic signed [W-1:0]   ma, mb;
    logic signed [2*W-1:0] ax, bx, prod;
    int                    cnt;
    assign ax   = ma;
    assign bx   = mb;
    assign prod = ax * bx;

    always @(posedge clk) begin
        if (reset) begin
            spm_done <= 1'b0;
            spm_p    <= '0;
            cnt      <= 0;
            ma       <= '0;
            mb       <= '0;
        end else if (spm_start) begin
            ma  <= spm_mp;
            mb  <= spm_mc;
            cnt <= LAT;
            if (!stale_mode)
                spm_done <= 1'b0;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (stale_mode && cnt == 3)
                spm_done <= 1'b0;
            if (cnt == 1) begin
                spm_done <= !hang;
                spm_p    <= prod;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && spm_start)
            start_cnt <= start_cnt + 1;
        if (!reset && out_valid && out_ready) begin
            got_p.push_back(out_p);
            got_err.push_back(out_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic signed [W-1:0] mp, input logic signed [W-1:0] mc);
        int k = 0;
        in_mp    = mp;
        in_mc    = mc;
        in_valid = 1'b1;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_accept: in_ready=%0b after %0d cycles, required 1", in_ready, k);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input string name);
        int k = 0;
        while (got_p.size() < n && k < 500) begin
            tick();
            k++;
        end
        checks++;
        if (got_p.size() < n) begin
            errors++;
            $display("FAIL %s_wait: got %0d outputs, required %0d", name, got_p.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %0b required 0", in_ready);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_high: got %0b required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || spm_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: out_valid=%0b out_err=%0b spm_start=%0b busy=%0b required all 0",
                     out_valid, out_err, spm_start, busy);
        end
        checks++;
        if (out_p !== 64'sd0 || spm_mp !== 32'sd0 || spm_mc !== 32'sd0) begin
            errors++;
            $display("FAIL reset_data: out_p=%0d spm_mp=%0d spm_mc=%0d required 0", out_p, spm_mp, spm_mc);
        end
    endtask

    task automatic test_single_op();
        int s0;
        got_p.delete();
        got_err.delete();
        out_ready = 1'b1;
        s0 = start_cnt;
        push(32'sd15, -32'sd13);
        tick();
        checks++;
        if (spm_start !== 1'b1 || spm_mp !== 32'sd15 || spm_mc !== -32'sd13) begin
            errors++;
            $display("FAIL single_issue: spm_start=%0b mp=%0d mc=%0d required 1 15 -13", spm_start, spm_mp, spm_mc);
        end
        wait_outputs(1, "single");
        repeat (3) tick();
        checks++;
        if (got_p.size() != 1 || got_p[0] !== -64'sd195 || got_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_result: count=%0d p=%0d err=%0b required 1 -195 0",
                     got_p.size(), got_p.size() > 0 ? got_p[0] : 64'sd0, got_err.size() > 0 ? got_err[0] : 1'b0);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL single_start_pulses: got %0d required 1", start_cnt - s0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %0b required 0", busy);
        end
    endtask

    task automatic test_extremes();
        logic signed [2*W-1:0] exp_p [3];
        exp_p[0] = 64'sh4000000000000000;
        exp_p[1] = 64'shC000000080000000;
        exp_p[2] = 64'sd0;
        got_p.delete();
        got_err.delete();
        push(32'sh80000000, 32'sh80000000);
        push(32'sh7FFFFFFF, 32'sh80000000);
        push(32'sd0, 32'sd12345);
        wait_outputs(3, "extremes");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_p.size() <= i || got_p[i] !== exp_p[i] || got_err[i] !== 1'b0) begin
                errors++;
                $display("FAIL extremes_%0d: got %h required %h", i,
                         got_p.size() > i ? got_p[i] : 64'sd0, exp_p[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0]   mp [5];
        logic signed [W-1:0]   mc [5];
        logic signed [2*W-1:0] exp_p [5];
        bit saw_ready = 0;
        mp[0] = 1;  mc[0] = 2;   exp_p[0] = 2;
        mp[1] = -3; mc[1] = 4;   exp_p[1] = -12;
        mp[2] = 5;  mc[2] = -6;  exp_p[2] = -30;
        mp[3] = 7;  mc[3] = 8;   exp_p[3] = 56;
        mp[4] = -9; mc[4] = -10; exp_p[4] = 90;
        got_p.delete();
        got_err.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(mp[i], mc[i]);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: in_ready=%0b after 5 pairs, required 0", in_ready);
        end
        in_mp    = 32'sd11;
        in_mc    = 32'sd11;
        in_valid = 1'b1;
        repeat (30) begin
            tick();
            if (in_ready)
                saw_ready = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (saw_ready) begin
            errors++;
            $display("FAIL bp_sixth_blocked: in_ready rose while stalled, required 0");
        end
        checks++;
        if (out_valid !== 1'b1 || out_p !== 64'sd2) begin
            errors++;
            $display("FAIL bp_hold: out_valid=%0b out_p=%0d required 1 2", out_valid, out_p);
        end
        out_ready = 1'b1;
        wait_outputs(5, "bp");
        repeat (40) tick();
        checks++;
        if (got_p.size() != 5) begin
            errors++;
            $display("FAIL bp_count: got %0d products required 5", got_p.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_p.size() <= i || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL bp_order_%0d: got %0d required %0d", i,
                         got_p.size() > i ? got_p[i] : 64'sd0, exp_p[i]);
            end
        end
    endtask

    task automatic test_stale_done();
        got_p.delete();
        got_err.delete();
        stale_mode = 0;
        push(32'sd3, 32'sd5);
        wait_outputs(1, "stale_prev");
        repeat (3) tick();
        stale_mode = 1;
        push(32'sd7, -32'sd9);
        wait_outputs(2, "stale");
        repeat (5) tick();
        stale_mode = 0;
        checks++;
        if (got_p.size() != 2 || got_p[0] !== 64'sd15 || got_p[1] !== -64'sd63) begin
            errors++;
            $display("FAIL stale_done: count=%0d last=%0d required 2 outputs ending -63",
                     got_p.size(), got_p.size() > 0 ? got_p[got_p.size()-1] : 64'sd0);
        end
    endtask

    task automatic test_reset_mid_wait();
        got_p.delete();
        got_err.delete();
        push(32'sd2, 32'sd3);
        push(32'sd4, 32'sd5);
        push(32'sd6, 32'sd7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: out_valid=%0b busy=%0b required 0 0", out_valid, busy);
        end
        repeat (40) tick();
        checks++;
        if (got_p.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_no_output: got %0d products required 0", got_p.size());
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: in_ready=%0b busy=%0b required 1 0", in_ready, busy);
        end
        push(-32'sd4, 32'sd25);
        wait_outputs(1, "rst_mid_next");
        repeat (3) tick();
        checks++;
        if (got_p.size() != 1 || got_p[0] !== -64'sd100) begin
            errors++;
            $display("FAIL rst_mid_next: count=%0d p=%0d required 1 -100",
                     got_p.size(), got_p.size() > 0 ? got_p[0] : 64'sd0);
        end
    endtask

`ifdef SPM_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0;
        got_p.delete();
        got_err.delete();
        hang = 1;
        push(32'sd9, 32'sd9);
        tick();
        checks++;
        if (spm_start !== 1'b1) begin
            errors++;
            $display("FAIL tout_start: spm_start=%0b required 1", spm_start);
        end
        while (!out_valid && k < 400) begin
            tick();
            k++;
        end
        checks++;
        if (k != TOUT + 1) begin
            errors++;
            $display("FAIL tout_latency: got %0d cycles required %0d", k, TOUT + 1);
        end
        checks++;
        if (out_err !== 1'b1 || out_p !== 64'sd0) begin
            errors++;
            $display("FAIL tout_result: err=%0b p=%0d required 1 0", out_err, out_p);
        end
        hang = 0;
        push(32'sd6, 32'sd7);
        wait_outputs(2, "tout_next");
        checks++;
        if (got_p.size() < 2 || got_p[1] !== 64'sd42 || got_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL tout_next: p=%0d err=%0b required 42 0",
                     got_p.size() > 1 ? got_p[1] : 64'sd0, got_err.size() > 1 ? got_err[1] : 1'b0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_extremes();
        test_backpressure();
        test_stale_done();
        test_reset_mid_wait();
`ifdef SPM_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
